// File: rtl/uart_alu_rsp_framer.sv
// rtl/uart_alu_rsp_framer.sv - UART ALU response packet framer (header + payload stream, optional XOR trailer via UART_ALU_RSP_CHKSUM_EN)
module uart_alu_rsp_framer #(
  parameter int HdrBytes   = 4,
  parameter int MaxPayload = 1020
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rsp_valid_i,
  output logic        rsp_ready_o,
  input  logic [7:0]  rsp_opcode_i,
  input  logic [15:0] rsp_len_i,
  input  logic [7:0]  pl_data_i,
  input  logic        pl_valid_i,
  output logic        pl_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        busy_o,
  output logic        len_err_o
);

`ifdef UART_ALU_RSP_CHKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, CHK, DONE} state_t;
  localparam logic [15:0] TrailBytes = 16'd1;
`else
  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DONE} state_t;
  localparam logic [15:0] TrailBytes = 16'd0;
`endif

  localparam logic [15:0] MaxLen = 16'(MaxPayload);
  localparam logic [15:0] HdrLen = 16'(HdrBytes);

  state_t      state;
  logic [1:0]  hdr_idx;
  logic [15:0] remaining;
  logic [15:0] total_len;
  logic [15:0] len_c;
  logic [7:0]  hdr_next;
  logic        slot_free;
  logic        pl_phase;
  logic        pl_fire;
  logic        rsp_fire;

  assign len_c     = (rsp_len_i > MaxLen) ? MaxLen : rsp_len_i;
  assign slot_free = !tx_valid_o || tx_ready_i;
  // The first payload byte is fetched while header byte 3 drains, so the stream has no bubble.
  assign pl_phase   = (state == PAYLOAD) || ((state == HDR) && (hdr_idx == 2'd3));
  assign pl_ready_o = pl_phase && (remaining != 16'd0) && slot_free;
  assign pl_fire    = pl_valid_i && pl_ready_o;
  assign rsp_fire   = rsp_valid_i && rsp_ready_o;
  assign busy_o     = (state != IDLE);

  always_comb begin
    hdr_next = 8'h00;
    case (hdr_idx)
      2'd1:    hdr_next = total_len[7:0];
      2'd2:    hdr_next = total_len[15:8];
      default: hdr_next = 8'h00;
    endcase
  end

`ifdef UART_ALU_RSP_CHKSUM_EN
  logic [7:0] chk_q;

  // Running XOR of every byte loaded into the output slot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      chk_q <= 8'h00;
    end else if (rsp_fire) begin
      chk_q <= rsp_opcode_i;
    end else if ((state == HDR) && tx_ready_i && (hdr_idx != 2'd3)) begin
      chk_q <= chk_q ^ hdr_next;
    end else if (pl_fire) begin
      chk_q <= chk_q ^ pl_data_i;
    end
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      hdr_idx     <= 2'd0;
      remaining   <= 16'd0;
      total_len   <= 16'd0;
      rsp_ready_o <= 1'b0;
      tx_valid_o  <= 1'b0;
      tx_data_o   <= 8'h00;
      len_err_o   <= 1'b0;
    end else begin
      len_err_o <= 1'b0;
      case (state)
        IDLE: begin
          rsp_ready_o <= 1'b1;
          if (rsp_fire) begin
            rsp_ready_o <= 1'b0;
            remaining   <= len_c;
            total_len   <= len_c + HdrLen + TrailBytes;
            len_err_o   <= (rsp_len_i > MaxLen);
            hdr_idx     <= 2'd0;
            tx_valid_o  <= 1'b1;
            tx_data_o   <= rsp_opcode_i;
            state       <= HDR;
          end
        end
        HDR: begin
          if (tx_ready_i) begin
            if (hdr_idx != 2'd3) begin
              hdr_idx   <= hdr_idx + 2'd1;
              tx_data_o <= hdr_next;
            end else if (remaining != 16'd0) begin
              state <= PAYLOAD;
              if (pl_fire) begin
                tx_data_o <= pl_data_i;
                remaining <= remaining - 16'd1;
              end else begin
                tx_valid_o <= 1'b0;
              end
            end else begin
`ifdef UART_ALU_RSP_CHKSUM_EN
              tx_data_o <= chk_q;
              state     <= CHK;
`else
              tx_valid_o <= 1'b0;
              state      <= DONE;
`endif
            end
          end
        end
        PAYLOAD: begin
          if (pl_fire) begin
            tx_valid_o <= 1'b1;
            tx_data_o  <= pl_data_i;
            remaining  <= remaining - 16'd1;
          end else if (tx_ready_i) begin
            tx_valid_o <= 1'b0;
          end
          if ((remaining == 16'd0) && slot_free) begin
`ifdef UART_ALU_RSP_CHKSUM_EN
            tx_valid_o <= 1'b1;
            tx_data_o  <= chk_q;
            state      <= CHK;
`else
            tx_valid_o <= 1'b0;
            state      <= DONE;
`endif
          end
        end
`ifdef UART_ALU_RSP_CHKSUM_EN
        CHK: begin
          if (tx_ready_i) begin
            tx_valid_o <= 1'b0;
            state      <= DONE;
          end
        end
`endif
        DONE: begin
          rsp_ready_o <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
